sobel_edge_core: RTL and testbench

Parametrised Sobel edge detector, the successor to sobel_detec. It sits after rgb2ycbcr on the Y channel of the video-stream chain (vsync/hsync/valid/data). It builds a 3x3 window from two internal line buffers and computes |Gx|+|Gy|. Output is binary edge, saturated magnitude, or threshold-gated magnitude, with a fixed pipeline latency and a per-frame latched threshold.

---
 rtl/sobel_edge_core.sv | 199 +++++++++++++++++++
 tb/tb_sobel_edge_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_core.sv
// sobel_edge_core: 3x3 Sobel edge detector on a luminance video stream.
// Two line buffers plus a 3x3 window feed a four-stage pipeline that produces
// |Gx|+|Gy|. The result is presented as a binary edge, a saturated magnitude or
// a threshold-gated magnitude. The threshold is latched once per frame.
`timescale 1ns/1ps
module sobel_edge_core #(
    parameter int DATA_W    = 8,
    parameter int MAX_H_RES = 1024,
    parameter int OUT_MODE  = 0,
    parameter int LAT       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+2:0] thresh,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_data,
    output logic              line_ovf
);

    localparam int GW = DATA_W + 3;
    localparam int AW = (MAX_H_RES > 1) ? $clog2(MAX_H_RES) : 1;
    localparam int CW = AW + 1;
    localparam int RW = 12;

    // Zero-extend a pixel into the signed gradient width.
    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
        return v[GW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] sat_mag(input logic [GW-1:0] g);
        return (g > GW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : g[DATA_W-1:0];
    endfunction

    // Final output formatting; the threshold comparison is strictly greater-than.
    function automatic logic [DATA_W-1:0] sel_out(input logic [GW-1:0] g,
                                                  input logic [GW-1:0] th);
        logic hit;
        hit = (g > th);
        if (OUT_MODE == 0)
            return hit ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        else if (OUT_MODE == 1)
            return sat_mag(g);
        else
            return hit ? sat_mag(g) : {DATA_W{1'b0}};
    endfunction

    logic                     vs_q, hs_q, vs_rise, hs_fall;
    logic [CW-1:0]            col, col_cur;
    logic [RW-1:0]            row, row_cur;
    logic [GW-1:0]            thresh_q;
    logic                     in_range;
    logic [AW-1:0]            addr;
    logic [DATA_W-1:0]        lb1 [MAX_H_RES];
    logic [DATA_W-1:0]        lb2 [MAX_H_RES];
    logic [DATA_W-1:0]        lb1_rd, lb2_rd;
    logic [DATA_W-1:0]        win [3][3];
    logic                     vld_p0, vld_p1, vld_p2;
    logic                     zero_p0, zero_p1, zero_p2;
    logic signed [GW-1:0]     gx_p1, gy_p1;
    logic [GW-1:0]            g_p2;
    logic [LAT-1:0]           vs_dly, hs_dly;

    // A vsync rise restarts the frame, so the pixel arriving with it already
    // sees row 0 / col 0.
    assign vs_rise  = pre_img_vsync & ~vs_q;
    assign hs_fall  = hs_q & ~pre_img_hsync;
    assign col_cur  = vs_rise ? '0 : col;
    assign row_cur  = vs_rise ? '0 : row;
    assign in_range = (col_cur < CW'(MAX_H_RES));
    assign addr     = col_cur[AW-1:0];
    assign lb1_rd   = in_range ? lb1[addr] : '0;
    assign lb2_rd   = in_range ? lb2[addr] : '0;

    // Frame/line position tracking, per-frame threshold latch and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            col      <= '0;
            row      <= '0;
            thresh_q <= '0;
            line_ovf <= 1'b0;
        end else begin
            vs_q <= pre_img_vsync;
            hs_q <= pre_img_hsync;
            if (vs_rise)
                thresh_q <= thresh;
            if (pre_img_valid && !in_range)
                line_ovf <= 1'b1;
            else if (vs_rise)
                line_ovf <= 1'b0;
            if (hs_fall)
                col <= '0;
            else if (pre_img_valid && col_cur != '1)
                col <= col_cur + CW'(1);
            else
                col <= col_cur;
            // Empty lines (no valid pixel) do not advance the row.
            if (hs_fall && col_cur != '0 && row_cur != '1)
                row <= row_cur + RW'(1);
            else
                row <= row_cur;
        end
    end

    // Line buffers: read-before-write, previous line cascades into lb2.
    always_ff @(posedge clk) begin
        if (pre_img_valid && in_range) begin
            lb1[addr] <= pre_img_data;
            lb2[addr] <= lb1[addr];
        end
    end

    // ---- stage 1: window shift and line-buffer read ----
    // Window advances one column per valid pixel; border/overflow pixels are marked for zeroing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            vld_p0  <= 1'b0;
            zero_p0 <= 1'b0;
        end else begin
            if (pre_img_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pre_img_data;
            end
            vld_p0  <= pre_img_valid;
            zero_p0 <= (row_cur < RW'(2)) | (col_cur < CW'(2)) | ~in_range;
        end
    end

    // ---- stage 2: gradient partial sums; stage 3: |Gx|+|Gy| ----
    // Gradient datapath; qualified downstream by vld/zero, so no reset needed.
    always_ff @(posedge clk) begin
        gx_p1 <= (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
               - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy_p1 <= (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
               - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
        g_p2  <= abs_val(gx_p1) + abs_val(gy_p1);
    end

    // Control that travels alongside the gradient datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            zero_p1 <= 1'b0;
            zero_p2 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            zero_p1 <= zero_p0;
            zero_p2 <= zero_p1;
        end
    end

    // ---- stage 4: mode select into the output register ----
    // Output pixel; forced to zero when not valid or when masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_img_valid <= 1'b0;
            post_img_data  <= '0;
        end else begin
            post_img_valid <= vld_p2;
            post_img_data  <= (vld_p2 && !zero_p2) ? sel_out(g_p2, thresh_q) : '0;
        end
    end

    // Sync signals are plain LAT-deep delays, independent of the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_dly <= '0;
            hs_dly <= '0;
        end else begin
            vs_dly <= {vs_dly[LAT-2:0], pre_img_vsync};
            hs_dly <= {hs_dly[LAT-2:0], pre_img_hsync};
        end
    end

    assign post_img_vsync = vs_dly[LAT-1];
    assign post_img_hsync = hs_dly[LAT-1];

endmodule

// File: tb/tb_sobel_edge_core.sv
// Scoreboard bench for sobel_edge_core: three instances (OUT_MODE 0/1/2,
// MAX_H_RES 16) share one input stream; a frame-level reference model pushes
// expected pixels, and a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sobel_edge_core;
    localparam int DW   = 8;
    localparam int MAXH = 16;
    localparam int LATC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW+2:0] thresh;
    logic          vs, hs, vld;
    logic [DW-1:0] din;
    logic [2:0]    p_vs, p_hs, p_vld, p_ovf;
    logic [DW-1:0] p_data [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sync_from = 8;
    int ovf_req = -1;
    int frame_th = 0;
    int exp_d [3][$];
    int exp_c [3][$];
    int pushed [3];
    int popped [3];
    bit hist_vs [16];
    bit hist_hs [16];
    bit hist_vld [16];
    int img [8][24];

    genvar gm;
    generate
        for (gm = 0; gm < 3; gm++) begin : g_dut
            sobel_edge_core #(.DATA_W(DW), .MAX_H_RES(MAXH), .OUT_MODE(gm), .LAT(LATC)) dut (
                .clk            (clk),
                .rst            (rst),
                .thresh         (thresh),
                .pre_img_vsync  (vs),
                .pre_img_hsync  (hs),
                .pre_img_valid  (vld),
                .pre_img_data   (din),
                .post_img_vsync (p_vs[gm]),
                .post_img_hsync (p_hs[gm]),
                .post_img_valid (p_vld[gm]),
                .post_img_data  (p_data[gm]),
                .line_ovf       (p_ovf[gm])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    // Cycle counter and input history used for the sync-delay reference.
    always @(posedge clk) begin
        hist_vs[cyc[3:0]]  <= vs;
        hist_hs[cyc[3:0]]  <= hs;
        hist_vld[cyc[3:0]] <= vld;
        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: Sobel on the stored frame image, border and overflow give 0.
    function automatic int model_pix(int mode, int r, int c, int th);
        int gx, gy, g, mag;
        if (r < 2 || c < 2 || c >= MAXH) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        g = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        mag = (g > 255) ? 255 : g;
        if (mode == 0) return (g > th) ? 255 : 0;
        if (mode == 1) return mag;
        return (g > th) ? mag : 0;
    endfunction

    task automatic drive(input bit v_vs, input bit v_hs, input bit v_vld, input int v_d);
        @(posedge clk);
        #1;
        if (ovf_req >= 0) begin
            for (int m = 0; m < 3; m++) check("line_ovf", int'(p_ovf[m]), ovf_req);
            ovf_req = -1;
        end
        vs = v_vs; hs = v_hs; vld = v_vld; din = v_d[DW-1:0];
    endtask

    task automatic push_pixel(input int r, input int c);
        for (int m = 0; m < 3; m++) begin
            exp_d[m].push_back(model_pix(m, r, c, frame_th));
            exp_c[m].push_back(cyc);
            pushed[m]++;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        for (int m = 0; m < 3; m++) check("pre_rst_valid", int'(p_vld[m]), 1);
        rst = 1'b1; vs = 1'b0; hs = 1'b0; vld = 1'b0; din = '0;
        for (int m = 0; m < 3; m++) begin
            exp_d[m].delete();
            exp_c[m].delete();
            pushed[m] = popped[m];
        end
        #1;
        for (int m = 0; m < 3; m++) begin
            check("rst_valid", int'(p_vld[m]), 0);
            check("rst_data", int'(p_data[m]), 0);
            check("rst_vsync", int'(p_vs[m]), 0);
            check("rst_hsync", int'(p_hs[m]), 0);
            check("rst_ovf", int'(p_ovf[m]), 0);
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        sync_from = cyc + 6;
    endtask

    task automatic run_frame(input int w, input int h, input int maxgap, input int chg_row,
                             input int new_th, input int abort_row, input bit ovf_test);
        drive(0, 0, 0, 0);
        frame_th = int'(thresh);
        drive(1, 0, 0, 0);
        ovf_req = 0;
        drive(1, 0, 0, 0);
        for (int r = 0; r < h; r++) begin
            if (r == chg_row) thresh = new_th[DW+2:0];
            drive(1, 1, 0, 0);
            for (int c = 0; c < w; c++) begin
                if (r == abort_row && c == 6) begin
                    reset_pulse();
                    return;
                end
                repeat (int'($urandom_range(0, maxgap))) drive(1, 1, 0, 0);
                drive(1, 1, 1, img[r][c]);
                push_pixel(r, c);
                if (ovf_test && r == 0 && c == MAXH - 1) ovf_req = 0;
                if (ovf_test && r == 0 && c == MAXH) ovf_req = 1;
            end
            drive(1, 1, 0, 0);
            drive(1, 0, 0, 0);
            drive(1, 0, 0, 0);
        end
        drive(0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0);
    endtask

    task automatic fill_uniform(input int v);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 24; c++) img[r][c] = v;
    endtask

    task automatic fill_vedge();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 24; c++) img[r][c] = (c < 4) ? 0 : 255;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 24; c++) img[r][c] = (10 * c) % 256;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 24; c++) img[r][c] = int'($urandom_range(0, 255));
    endtask

    // Monitor: pops the scoreboard on every output pixel, checks sync delays.
    always @(negedge clk) begin : monitor
        int d, c, idx;
        if (!rst) begin
            idx = (cyc - LATC) & 15;
            for (int m = 0; m < 3; m++) begin
                if (p_vld[m]) begin
                    if (exp_d[m].size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        d = exp_d[m].pop_front();
                        c = exp_c[m].pop_front();
                        popped[m]++;
                        check("pixel_data", int'(p_data[m]), d);
                        check("latency", cyc - c, LATC);
                    end
                end else begin
                    check("idle_data", int'(p_data[m]), 0);
                end
                if (cyc >= sync_from) begin
                    check("vsync_delay", int'(p_vs[m]), int'(hist_vs[idx]));
                    check("hsync_delay", int'(p_hs[m]), int'(hist_hs[idx]));
                    check("valid_delay", int'(p_vld[m]), int'(hist_vld[idx]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0; vld = 1'b0; din = '0; thresh = '0;
        #1;
        for (int m = 0; m < 3; m++) begin
            check("reset_valid", int'(p_vld[m]), 0);
            check("reset_data", int'(p_data[m]), 0);
            check("reset_vsync", int'(p_vs[m]), 0);
            check("reset_hsync", int'(p_hs[m]), 0);
            check("reset_ovf", int'(p_ovf[m]), 0);
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        fill_uniform(100); thresh = 11'd128;
        run_frame(8, 4, 0, -1, 0, -1, 1'b0);

        fill_vedge(); thresh = 11'd128;
        run_frame(8, 4, 1, -1, 0, -1, 1'b0);

        fill_ramp(); thresh = 11'd80;
        run_frame(8, 4, 0, -1, 0, -1, 1'b0);
        thresh = 11'd79;
        run_frame(8, 4, 2, -1, 0, -1, 1'b0);

        fill_vedge(); thresh = 11'd128;
        run_frame(8, 4, 0, 1, 2000, -1, 1'b0);
        run_frame(8, 4, 0, -1, 0, -1, 1'b0);

        fill_random(); thresh = 11'd100;
        run_frame(20, 3, 1, -1, 0, -1, 1'b1);
        for (int m = 0; m < 3; m++) check("ovf_sticky", int'(p_ovf[m]), 1);

        for (int k = 0; k < 4; k++) begin
            fill_random();
            thresh = 11'($urandom_range(0, 2047));
            run_frame(int'($urandom_range(3, 14)), int'($urandom_range(3, 6)), 2, -1, 0, -1, 1'b0);
        end

        fill_vedge(); thresh = 11'd128;
        run_frame(8, 4, 0, -1, 0, 2, 1'b0);
        repeat (4) drive(0, 0, 0, 0);
        run_frame(8, 4, 1, -1, 0, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if (exp_d[0].size() == 0 && exp_d[1].size() == 0 && exp_d[2].size() == 0) break;
            @(negedge clk);
        end
        #1;
        for (int m = 0; m < 3; m++) begin
            check("queue_drained", exp_d[m].size(), 0);
            check("pixel_count", popped[m], pushed[m]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
